// File: rtl/enemy_pkg.sv
// Shared types, widths and helpers for the enemy wave sequencing logic.
package enemy_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PLAY       = 2'd1,
      CLEAR_WAIT = 2'd2
   } wave_state_t;

   localparam int         ENEMY_ID_W  = 4;
   localparam int         MAX_ENEMIES = 16;
   localparam int         LEVEL_W     = 4;
   localparam int         SPEED_W     = 11;
   localparam int         CNT_W       = 16;
   localparam logic [3:0] MAX_LEVEL   = 4'd15;

   // Speed for a level, computed wide so the sum never wraps before saturation.
   function automatic logic [SPEED_W-1:0] calc_speed(
      input logic [LEVEL_W-1:0] lvl,
      input int                 base,
      input int                 step,
      input int                 max_speed
   );
      logic [15:0] raw;
      raw = 16'(base) + 16'(lvl) * 16'(step);
      if (raw > 16'(max_speed)) begin
         return SPEED_W'(max_speed);
      end
      return SPEED_W'(raw);
   endfunction

endpackage

// File: rtl/enemy_rr_picker.sv
// Round-robin picker: first set bit of mask strictly after start, wrapping
// around N. Purely combinational so the stock manager can reuse it.
module enemy_rr_picker
   import enemy_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]            mask,
   input  logic [ENEMY_ID_W-1:0]   start,
   output logic                    found,
   output logic [ENEMY_ID_W-1:0]   id
);

   localparam int IW = ENEMY_ID_W + 1;

   logic [MAX_ENEMIES-1:0] mask_ext;
   logic [IW-1:0]          idx;

   // Walk candidates start+1 .. start+N (mod N); the first live one wins.
   always_comb begin
      mask_ext          = '0;
      mask_ext[N-1:0]   = mask;
      found             = 1'b0;
      id                = '0;
      idx               = '0;
      for (int k = 1; k <= N; k++) begin
         idx = {1'b0, start} + IW'(k);
         if (idx >= IW'(N)) begin
            idx = idx - IW'(N);
         end
         if (!found && mask_ext[idx[ENEMY_ID_W-1:0]]) begin
            found = 1'b1;
            id    = idx[ENEMY_ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/enemy_wave_controller.sv
// Enemy wave sequencer: tracks live enemies, clears a wave when the last one
// dies, waits a number of frames, then starts the next (faster) level. Also
// schedules enemy fire round-robin among the live enemies.
//
// Fire handshake: fireReq is a valid that, once raised, holds with fireId
// stable until the cycle fireAck is sampled high (transfer happens on that
// edge, fireReq low the following cycle). The request may also be withdrawn
// without a transfer when the firing enemy is killed or the wave leaves PLAY.
// An ack in the same cycle as such a withdrawal still counts as a transfer.
module enemy_wave_controller
   import enemy_pkg::*;
#(
   parameter int AMOUNT_OF_ENEMIES = 2,
   parameter int BASE_SPEED        = 64,
   parameter int SPEED_STEP        = 16,
   parameter int MAX_SPEED         = 256,
   parameter int FIRE_PERIOD       = 60,
   parameter int LEVEL_DELAY       = 90
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         startOfFrame,
   input  logic                         pause,
   input  logic                         gameStart,
   input  logic                         hitValid,
   input  logic [ENEMY_ID_W-1:0]        hitId,
   input  logic                         fireAck,
   output logic [AMOUNT_OF_ENEMIES-1:0] aliveMask,
   output logic                         newLevel,
   output logic [LEVEL_W-1:0]           level,
   output logic [SPEED_W-1:0]           enemySpeed,
   output logic                         waveClear,
   output logic                         fireReq,
   output logic [ENEMY_ID_W-1:0]        fireId,
   output logic [1:0]                   waveState
);

   localparam int             N          = AMOUNT_OF_ENEMIES;
   localparam logic [N-1:0]   ALL_ALIVE  = {N{1'b1}};
   localparam logic [1:0]     S_IDLE     = IDLE;
   localparam logic [1:0]     S_PLAY     = PLAY;
   localparam logic [1:0]     S_CLEAR    = CLEAR_WAIT;
   localparam logic [CNT_W-1:0] FIRE_LAST  = CNT_W'(FIRE_PERIOD - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(LEVEL_DELAY - 1);

   logic [CNT_W-1:0]        fire_cnt;
   logic [CNT_W-1:0]        delay_cnt;
   logic [ENEMY_ID_W-1:0]   last_fired;

   logic [MAX_ENEMIES-1:0]  alive_ext;
   logic                    hit_in_range;
   logic                    hit_eff;
   logic [N-1:0]            hit_clear;
   logic [N-1:0]            alive_next;
   logic                    hit_on_fire;
   logic                    frame_tick;
   logic                    fire_wrap;
   logic                    delay_done;
   logic                    leave_play;
   logic [LEVEL_W-1:0]      level_up;
   logic                    pick_found;
   logic [ENEMY_ID_W-1:0]   pick_id;

   // Hit qualification, frame events and next-level value.
   always_comb begin
      alive_ext        = '0;
      alive_ext[N-1:0] = aliveMask;
      hit_in_range     = ({1'b0, hitId} < 5'(N));
      hit_eff          = (waveState == S_PLAY) && hitValid && hit_in_range
                         && alive_ext[hitId];
      hit_clear        = '0;
      for (int i = 0; i < N; i++) begin
         hit_clear[i] = hit_eff && (hitId == ENEMY_ID_W'(i));
      end
      alive_next  = aliveMask & ~hit_clear;
      hit_on_fire = hit_eff && (hitId == fireId);
      frame_tick  = startOfFrame && !pause;
      fire_wrap   = frame_tick && (fire_cnt == FIRE_LAST);
      delay_done  = frame_tick && (delay_cnt == DELAY_LAST);
      // A kill during pause is kept, but the wave only ends once unpaused.
      leave_play  = (waveState == S_PLAY) && !pause && (alive_next == '0);
      level_up    = (level == MAX_LEVEL) ? level : level + 4'd1;
   end

   // Next live shooter after the last one that actually fired. Searching the
   // post-hit mask keeps a dying enemy from being selected.
   enemy_rr_picker #(
      .N (N)
   ) u_picker (
      .mask  (alive_next),
      .start (last_fired),
      .found (pick_found),
      .id    (pick_id)
   );

   // Wave state machine, alive mask, level/speed and frame counters.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         waveState  <= S_IDLE;
         aliveMask  <= '0;
         newLevel   <= 1'b0;
         level      <= '0;
         enemySpeed <= SPEED_W'(BASE_SPEED);
         waveClear  <= 1'b0;
         fire_cnt   <= '0;
         delay_cnt  <= '0;
      end else begin
         newLevel <= 1'b0;
         case (waveState)
            S_IDLE: begin
               if (gameStart && !pause) begin
                  waveState  <= S_PLAY;
                  aliveMask  <= ALL_ALIVE;
                  level      <= '0;
                  enemySpeed <= calc_speed('0, BASE_SPEED, SPEED_STEP, MAX_SPEED);
                  newLevel   <= 1'b1;
                  fire_cnt   <= '0;
                  delay_cnt  <= '0;
               end
            end
            S_PLAY: begin
               aliveMask <= alive_next;
               if (leave_play) begin
                  waveState <= S_CLEAR;
                  waveClear <= 1'b1;
                  fire_cnt  <= '0;
                  delay_cnt <= '0;
               end else if (frame_tick) begin
                  fire_cnt <= fire_wrap ? '0 : fire_cnt + CNT_W'(1);
               end
            end
            S_CLEAR: begin
               if (delay_done) begin
                  waveState  <= S_PLAY;
                  waveClear  <= 1'b0;
                  aliveMask  <= ALL_ALIVE;
                  level      <= level_up;
                  enemySpeed <= calc_speed(level_up, BASE_SPEED, SPEED_STEP, MAX_SPEED);
                  newLevel   <= 1'b1;
                  fire_cnt   <= '0;
                  delay_cnt  <= '0;
               end else if (frame_tick) begin
                  delay_cnt <= delay_cnt + CNT_W'(1);
               end
            end
            default: begin
               waveState <= S_IDLE;
            end
         endcase
      end
   end

   // Fire request handshake and round-robin history.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         fireReq    <= 1'b0;
         fireId     <= '0;
         last_fired <= ENEMY_ID_W'(N - 1);
      end else begin
         if (fireReq && fireAck) begin
            // Ack wins over a same-cycle kill or wave end: the shot counts.
            fireReq    <= 1'b0;
            last_fired <= fireId;
         end else if (fireReq && ((waveState != S_PLAY) || leave_play || hit_on_fire)) begin
            fireReq <= 1'b0;
         end else if (!fireReq && (waveState == S_PLAY) && !leave_play
                      && fire_wrap && pick_found) begin
            fireReq <= 1'b1;
            fireId  <= pick_id;
         end
      end
   end

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Directed bench for enemy_wave_controller: wave clear/level sequencing,
// round-robin fire, kill-vs-ack ordering, pause and level saturation.
module tb_enemy_wave_controller;
   import enemy_pkg::*;

   localparam int N = 2;

   logic          clk;
   logic          resetN;
   logic          startOfFrame;
   logic          pause;
   logic          gameStart;
   logic          hitValid;
   logic [3:0]    hitId;
   logic          fireAck;
   logic [N-1:0]  aliveMask;
   logic          newLevel;
   logic [3:0]    level;
   logic [10:0]   enemySpeed;
   logic          waveClear;
   logic          fireReq;
   logic [3:0]    fireId;
   logic [1:0]    waveState;

   int tests_run    = 0;
   int tests_failed = 0;
   int nl_count     = 0;
   int nl_before    = 0;
   logic [3:0] exp_q[$];

   enemy_wave_controller #(
      .AMOUNT_OF_ENEMIES (N),
      .BASE_SPEED        (64),
      .SPEED_STEP        (16),
      .MAX_SPEED         (256),
      .FIRE_PERIOD       (2),
      .LEVEL_DELAY       (90)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .pause        (pause),
      .gameStart    (gameStart),
      .hitValid     (hitValid),
      .hitId        (hitId),
      .fireAck      (fireAck),
      .aliveMask    (aliveMask),
      .newLevel     (newLevel),
      .level        (level),
      .enemySpeed   (enemySpeed),
      .waveClear    (waveClear),
      .fireReq      (fireReq),
      .fireId       (fireId),
      .waveState    (waveState)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Counts newLevel pulses seen at clock edges.
   always @(posedge clk) begin
      if (resetN && newLevel) nl_count++;
   end

   function automatic int exp_speed(input int lvl);
      int s;
      s = 64 + 16 * lvl;
      return (s > 256) ? 256 : s;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_pulse();
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
      step();
   endtask

   task automatic kill(input int id);
      hitValid = 1'b1;
      hitId    = 4'(id);
      step();
      hitValid = 1'b0;
   endtask

   // Runs 'pre' frames of the clear delay, then the final frame, and checks
   // the new level comes up exactly there.
   task automatic run_delay(input int pre, input int exp_level);
      nl_before = nl_count;
      repeat (pre) frame_pulse();
      check_eq("delay_hold_state", waveState, 2);
      check_eq("delay_no_early_newlevel", nl_count, nl_before);
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      check_eq("newlevel_pulse", newLevel, 1);
      check_eq("newlevel_level", level, exp_level);
      check_eq("newlevel_speed", enemySpeed, exp_speed(exp_level));
      check_eq("newlevel_alive", aliveMask, 3);
      check_eq("newlevel_waveclear", waveClear, 0);
      check_eq("newlevel_state", waveState, 1);
      step();
      check_eq("newlevel_one_cycle", newLevel, 0);
   endtask

   // Two frames from a fresh counter: the second raises the request.
   task automatic fire_request(input logic [3:0] exp_id);
      frame_pulse();
      check_eq("fire_not_early", fireReq, 0);
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      check_eq("fire_req_high", fireReq, 1);
      check_eq("fire_id", fireId, exp_id);
   endtask

   task automatic fire_cycle(input logic [3:0] exp_id);
      fire_request(exp_id);
      fireAck = 1'b1;
      step();
      fireAck = 1'b0;
      check_eq("fire_req_after_ack", fireReq, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_alive"}, aliveMask, 0);
      check_eq({tag, "_newlevel"}, newLevel, 0);
      check_eq({tag, "_level"}, level, 0);
      check_eq({tag, "_speed"}, enemySpeed, 64);
      check_eq({tag, "_waveclear"}, waveClear, 0);
      check_eq({tag, "_firereq"}, fireReq, 0);
      check_eq({tag, "_fireid"}, fireId, 0);
      check_eq({tag, "_state"}, waveState, 0);
   endtask

   initial begin
      resetN       = 1'b0;
      startOfFrame = 1'b0;
      pause        = 1'b0;
      gameStart    = 1'b0;
      hitValid     = 1'b0;
      hitId        = '0;
      fireAck      = 1'b0;
      repeat (3) step();
      check_reset_outputs("reset");
      resetN = 1'b1;
      step();

      // Start game.
      gameStart = 1'b1;
      step();
      gameStart = 1'b0;
      check_eq("start_newlevel", newLevel, 1);
      check_eq("start_alive", aliveMask, 3);
      check_eq("start_level", level, 0);
      check_eq("start_speed", enemySpeed, 64);
      check_eq("start_state", waveState, 1);
      step();
      check_eq("start_newlevel_drop", newLevel, 0);

      // Out-of-range hit ids are ignored.
      hitValid = 1'b1;
      hitId    = 4'd5;
      step();
      hitId    = 4'd2;
      step();
      hitValid = 1'b0;
      check_eq("hit_out_of_range", aliveMask, 3);

      // Hit on enemy 0 held 5 cycles, then enemy 1.
      hitValid = 1'b1;
      hitId    = 4'd0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("hit0_alive", aliveMask, 2);
         check_eq("hit0_no_clear", waveClear, 0);
      end
      hitId = 4'd1;
      step();
      hitValid = 1'b0;
      check_eq("hit1_alive", aliveMask, 0);
      check_eq("hit1_waveclear", waveClear, 1);
      check_eq("hit1_state", waveState, 2);
      run_delay(89, 1);

      // Round-robin fire 0,1,0 (history starts at the last index).
      exp_q.push_back(4'd0);
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd0);
      while (exp_q.size() > 0) fire_cycle(exp_q.pop_front());
      kill(1);
      check_eq("kill1_alive", aliveMask, 1);
      fire_cycle(4'd0);
      fire_cycle(4'd0);
      kill(0);
      check_eq("kill0_clear", waveClear, 1);
      run_delay(89, 2);

      // Level 2: pending request on 1 dropped by a kill, history untouched.
      fire_request(4'd1);
      kill(1);
      check_eq("drop_on_kill_req", fireReq, 0);
      check_eq("drop_on_kill_alive", aliveMask, 1);
      kill(0);
      run_delay(89, 3);

      // Level 3: same history picks 1 again; ack and kill together.
      fire_request(4'd1);
      fireAck  = 1'b1;
      hitValid = 1'b1;
      hitId    = 4'd1;
      step();
      fireAck  = 1'b0;
      hitValid = 1'b0;
      check_eq("ack_hit_req", fireReq, 0);
      check_eq("ack_hit_alive", aliveMask, 1);
      kill(0);
      check_eq("ack_hit_wave_clear", waveState, 2);

      // Pause during the clear delay.
      repeat (30) frame_pulse();
      pause     = 1'b1;
      nl_before = nl_count;
      repeat (200) frame_pulse();
      check_eq("pause_state", waveState, 2);
      check_eq("pause_no_newlevel", nl_count, nl_before);
      check_eq("pause_level", level, 3);
      pause = 1'b0;
      run_delay(59, 4);

      // The acked shot on 1 counted, so the next pick is 0.
      fire_cycle(4'd0);

      // Kills during pause land, but the clear waits for unpause.
      pause = 1'b1;
      kill(0);
      kill(1);
      check_eq("pause_kill_alive", aliveMask, 0);
      check_eq("pause_kill_state", waveState, 1);
      check_eq("pause_kill_noclear", waveClear, 0);
      pause = 1'b0;
      step();
      check_eq("unpause_clear_state", waveState, 2);
      check_eq("unpause_clear_flag", waveClear, 1);
      run_delay(89, 5);

      // Climb to level 15, then one more clear to confirm saturation.
      for (int lvl = 6; lvl <= 16; lvl++) begin
         kill(0);
         kill(1);
         run_delay(89, (lvl > 15) ? 15 : lvl);
      end
      check_eq("sat_speed", enemySpeed, 256);

      // Mid-wave asynchronous reset with a pending request.
      fire_request(4'd1);
      kill(0);
      check_eq("pre_reset_alive", aliveMask, 2);
      #3;
      resetN = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      step();
      resetN = 1'b1;
      step();
      gameStart = 1'b1;
      step();
      gameStart = 1'b0;
      check_eq("restart_level", level, 0);
      fire_request(4'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/enemy_wave_controller.md
# enemy_wave_controller

Sequences enemy waves for the enemy stock: tracks which enemies are alive, removes an enemy on a confirmed shot hit, and declares a wave cleared when all are dead. After a delay it starts the next level and raises enemy speed. It also schedules enemy fire round-robin among live enemies. It sits between the collision logic (hit id from the stock's drawing-requestor id) and the enemy stock, enemy-shot generator and HUD.

## Interface

**Parameters**
- AMOUNT_OF_ENEMIES, 2 — enemies managed; range 1..16.
- BASE_SPEED, 64 — enemySpeed at level 0.
- SPEED_STEP, 16 — speed added per level.
- MAX_SPEED, 256 — speed saturation value.
- FIRE_PERIOD, 60 — frames between fire attempts; ≥1.
- LEVEL_DELAY, 90 — frames between wave clear and the next level; ≥1.

**Ports**
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- pause  in  1  freezes all frame counting and state transitions.
- gameStart  in  1  level start request, honoured in IDLE only.
- hitValid  in  1  shot collided with an enemy this cycle.
- hitId  in  4  enemy index of the hit.
- fireAck  in  1  shot generator accepted the fire request.
- aliveMask  out  AMOUNT_OF_ENEMIES  1 = enemy alive, drawn, collidable.
- newLevel  out  1  one-cycle pulse; enemies reload start positions.
- level  out  4  current level, saturating at 15.
- enemySpeed  out  11  min(BASE_SPEED + level*SPEED_STEP, MAX_SPEED).
- waveClear  out  1  high while in CLEAR_WAIT.
- fireReq  out  1  fire request, held until acked or dropped.
- fireId  out  4  enemy that fires; stable while fireReq is high.

## Operation

**States**
- IDLE → PLAY on gameStart (when not paused): aliveMask = all ones, level = 0, newLevel pulse.
- PLAY → CLEAR_WAIT when a hit clears the last alive bit.
- CLEAR_WAIT → PLAY after LEVEL_DELAY startOfFrame pulses: aliveMask = all ones, level++ (saturating), newLevel pulse, frame counters cleared.

**Hits**
- Effective only in PLAY, when hitValid is high, hitId < AMOUNT_OF_ENEMIES, and aliveMask[hitId] = 1.
- An effective hit clears that bit.
- Repeated hits on a dead enemy (multi-pixel collisions in one frame) are ignored.
- hitId out of range is ignored.

**Fire scheduling**
- In PLAY, a frame counter counts startOfFrame while not paused.
- On reaching FIRE_PERIOD-1 the counter wraps to 0. If fireReq is low, the first alive index strictly after the last fired id (wrapping) is selected: fireReq = 1, fireId = that index.
- If no enemy is alive, no request is made.
- fireReq falls the cycle after fireAck.
- The request is dropped (fireReq = 0) if the enemy at fireId is killed or the state leaves PLAY.
- If fireAck and a hit on fireId arrive in the same cycle, the ack wins: the fire counts and the enemy dies.
- The last fired id updates only on ack.

**Pause**
- Counters hold, no transitions, no new fire requests.
- Hits are still processed: a kill during pause is counted, but the transition to CLEAR_WAIT waits for unpause.

**enemySpeed**
- Registered; computed at 12+ bits internally, then saturated.

## Timing

- Reset values: aliveMask 0, newLevel 0, level 0, enemySpeed BASE_SPEED, waveClear 0, fireReq 0, fireId 0; state IDLE; counters 0; last fired id = AMOUNT_OF_ENEMIES-1.
- All outputs are registered.
- Hit at edge t: aliveMask bit is 0 after t+1.
- Last kill at t: waveClear = 1 and state CLEAR_WAIT from t+1.
- newLevel is high exactly one cycle; level and enemySpeed update on the same edge as the newLevel rise.
- Fire: fireReq rises one cycle after the qualifying startOfFrame.
- Asserting resetN low mid-operation clears everything immediately, including a pending fireReq.

## Structure

- Package enemy_pkg:
  - wave_state_t enum {IDLE, PLAY, CLEAR_WAIT}.
  - ENEMY_ID_W = 4.
  - MAX_LEVEL = 15.
- Sub-module enemy_rr_picker: combinational next-set-bit search over aliveMask from a start index with wrap. It outputs found and id, and is reusable by the stock manager.

## Test plan

- Reset, then gameStart → newLevel pulse, aliveMask = 2'b11, level 0, enemySpeed 64.
- hitValid, hitId = 0 held 5 cycles, then hitId = 1 → aliveMask 2'b10, then 2'b00; waveClear rises one cycle after the second hit; after 90 frames newLevel pulses, level 1, enemySpeed 80, aliveMask 2'b11.
- FIRE_PERIOD = 2, both alive → fireId alternates 0, 1, 0 across acks. Kill enemy 1 → only fireId 0 is issued afterward.
- Pending fireReq with fireId = 1 and a hit on 1 (no ack) → fireReq = 0 next cycle. Same cycle ack + hit → fire counted and the enemy dies.
- Pause asserted during CLEAR_WAIT for 200 frames → no newLevel; release → exactly the remaining delay frames elapse.
- Force level to 15 via repeated clears → level stays 15, enemySpeed = min(64 + 240, 256) = 256. resetN pulse mid-wave → all outputs return to reset values.
